gf180mcu_osu_sc_gp9t3v3__tbuf_arb4: RTL and testbench
=====================================================

GF180MCU_OSU_SC_GP9T3V3__TBUF_ARB4 -- requirements
Module: gf180mcu_osu_sc_gp9t3v3__tbuf_arb4

Interface
REQ-001 SHALL have parameter MAXHOLD, default 8, giving the maximum consecutive DRIVE cycles before a forced release; legal range 2..255.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port R, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port REQ, input, 4 bits: per-requester request to drive the shared tri-state line; held high while using it.
REQ-005 SHALL have port GNT, output, 4 bits: registered, one-hot-or-zero grant.
REQ-006 SHALL have port OE, output, 4 bits: registered, one-hot-or-zero enables to the four tri-state buffers.
REQ-007 SHALL have port BUSY, output, 1 bit: high when state is DRIVE or TURN.

Function
REQ-008 SHALL implement three states: IDLE, DRIVE, TURN.
REQ-009 SHALL, in IDLE or TURN with REQ != 0, grant at the next edge, enter DRIVE, and set GNT and OE to the selected one-hot value (1-cycle request-to-grant latency).
REQ-010 SHALL select round-robin: search starts at index PTR and wraps 3->0; after granting index i, PTR becomes (i+1) mod 4.
REQ-011 SHALL, in IDLE or TURN with REQ == 0, go to (or stay in) IDLE with GNT = OE = 0.
REQ-012 SHALL, in DRIVE while REQ[g] stays high for the granted index g, hold GNT and OE unchanged.
REQ-013 SHALL, in DRIVE when REQ[g] is sampled low, clear GNT and OE at that edge and enter TURN.
REQ-014 SHALL keep TURN exactly one cycle with OE == 0 (break-before-make), so no two OE bits are ever high in the same or adjacent cycles.
REQ-015 SHALL keep a hold counter HCNT, 8 bits: cleared on entry to DRIVE, incremented each DRIVE cycle, saturating at MAXHOLD.
REQ-016 SHALL, when HCNT == MAXHOLD and any REQ bit other than g is high, force release at that edge into TURN (hold-limit feature only).
REQ-017 SHALL hold the grant past MAXHOLD with HCNT saturated while no other requester is pending.
REQ-018 SHALL ignore changes on non-granted REQ bits during DRIVE, except for evaluating REQ-016.
REQ-019 SHALL let a requester whose REQ drops and rises again within TURN compete normally at the TURN-exit edge under REQ-010.
REQ-020 SHALL keep GNT == OE in every cycle.

Reset
REQ-021 SHALL, while R is high and independent of CLK, force GNT = 0, OE = 0, BUSY = 0, state IDLE, PTR = 0, HCNT = 0.
REQ-022 SHALL, when R is asserted mid-DRIVE, drop OE in the same cycle without a TURN cycle; the first arbitration takes place at the first CLK edge after R deasserts.

Configuration
REQ-023 SHALL compile the hold-limit logic (HCNT, REQ-015 to REQ-017) only when macro TBUF_ARB_HOLD_LIMIT_EN is defined.
REQ-024 SHALL, without TBUF_ARB_HOLD_LIMIT_EN, hold a grant until REQ[g] drops; MAXHOLD is then ignored and the design has no counter flops.

Verification
REQ-025 SHALL cover: reset, then REQ = 0001 at edge 1 -> GNT = OE = 0001 after edge 1, BUSY = 1; REQ = 0000 -> OE = 0000, TURN for 1 cycle, then IDLE.
REQ-026 SHALL cover: REQ = 1111 held, each requester dropping its REQ after 2 cycles -> grant order 0001, 0010, 0100, 1000, 0001, with one OE = 0000 cycle between each grant.
REQ-027 SHALL cover (TBUF_ARB_HOLD_LIMIT_EN, MAXHOLD = 4): REQ = 0011 held -> 0001 granted for 4 cycles, TURN, then 0010 for 4 cycles, then back to 0001.
REQ-028 SHALL cover: REQ = 0100 held alone for 20 cycles with the limit enabled -> GNT stays 0100 and HCNT saturates at 4.
REQ-029 SHALL cover: R pulsed mid-DRIVE with GNT = 0010 -> OE = 0000 asynchronously; after release, REQ = 1010 -> GNT = 0010 (PTR reset to 0).
REQ-030 SHALL cover: a bench assertion checking every cycle that OE is one-hot-or-zero, and that no OE bit rises in the cycle following a cycle where a different OE bit was high.

Source files
------------

// File: rtl/gf180mcu_osu_sc_gp9t3v3__tbuf_arb4.sv
// Four-way round-robin arbiter for a shared tri-state line with break-before-make turnaround.
// Optional hold-limit (forced release after MAXHOLD cycles under contention): define TBUF_ARB_HOLD_LIMIT_EN.
module gf180mcu_osu_sc_gp9t3v3__tbuf_arb4 #(
    parameter int unsigned MAXHOLD = 8
) (
    input  logic       CLK,
    input  logic       R,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [3:0] OE,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [1:0] ptr_r;
    logic [1:0] ptr_s;
    logic [1:0] gidx_r;
    logic [1:0] gidx_s;
    logic [3:0] gnt_r;
    logic [3:0] oe_r;
    logic [3:0] gnt_s;
    logic       busy_r;
    logic [1:0] sel_s;
    logic [1:0] idx_s;
    logic       hit_s;
    logic       limit_s;

    // Round-robin pick: walk from ptr downwards in priority so the lowest offset wins.
    always_comb begin
        sel_s = ptr_r;
        idx_s = ptr_r;
        hit_s = |REQ;
        for (int k = 3; k >= 0; k--) begin
            idx_s = ptr_r + 2'(k);
            sel_s = REQ[idx_s] ? idx_s : sel_s;
        end
    end

`ifdef TBUF_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAXHOLD);

    logic [7:0] hcnt_r;
    logic [7:0] hcnt_s;
    logic [7:0] hcnt_inc_s;

    // Saturating count of completed DRIVE cycles; release fires when this cycle reaches the limit.
    always_comb begin
        hcnt_inc_s = (hcnt_r == HOLD_MAX) ? hcnt_r : (hcnt_r + 8'd1);
        limit_s    = (hcnt_inc_s == HOLD_MAX) && ((REQ & ~gnt_r) != 4'd0);
    end

    // Clear on entry to DRIVE, advance while DRIVE is kept, freeze otherwise.
    always_comb begin
        hcnt_s = hcnt_r;
        if ((state_s == DRIVE) && (state_r != DRIVE)) begin
            hcnt_s = 8'd0;
        end else if (state_s == DRIVE) begin
            hcnt_s = hcnt_inc_s;
        end else begin
            hcnt_s = hcnt_r;
        end
    end

    // Hold counter register.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            hcnt_r <= 8'd0;
        end else begin
            hcnt_r <= hcnt_s;
        end
    end
`else
    assign limit_s = 1'b0;
`endif

    // Next-state and next-grant decode.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        gidx_s  = gidx_r;
        gnt_s   = gnt_r;
        case (state_r)
            DRIVE: begin
                if (!REQ[gidx_r] || limit_s) begin
                    state_s = TURN;
                    gnt_s   = 4'd0;
                end else begin
                    state_s = DRIVE;
                end
            end
            IDLE, TURN: begin
                if (hit_s) begin
                    state_s = DRIVE;
                    gnt_s   = 4'b0001 << sel_s;
                    gidx_s  = sel_s;
                    ptr_s   = sel_s + 2'd1;
                end else begin
                    state_s = IDLE;
                    gnt_s   = 4'd0;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = 4'd0;
            end
        endcase
    end

    // State, pointer and output registers; GNT and OE share one next value so they never differ.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_r <= IDLE;
            ptr_r   <= 2'd0;
            gidx_r  <= 2'd0;
            gnt_r   <= 4'd0;
            oe_r    <= 4'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            gidx_r  <= gidx_s;
            gnt_r   <= gnt_s;
            oe_r    <= gnt_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    assign GNT  = gnt_r;
    assign OE   = oe_r;
    assign BUSY = busy_r;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__tbuf_arb4.sv
// Scoreboard bench: a cycle-level reference model pushes expectations, a monitor pops and compares.
`timescale 1ns/1ps
module tb_gf180mcu_osu_sc_gp9t3v3__tbuf_arb4;

    localparam int MAXHOLD = 4;
`ifdef TBUF_ARB_HOLD_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       R = 1'b1;
    logic [3:0] REQ = 4'd0;
    logic [3:0] GNT;
    logic [3:0] OE;
    logic       BUSY;

    gf180mcu_osu_sc_gp9t3v3__tbuf_arb4 #(.MAXHOLD(MAXHOLD)) dut (
        .CLK(CLK), .R(R), .REQ(REQ), .GNT(GNT), .OE(OE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] gnt;
        logic       busy;
        logic       drive;
        logic [7:0] hcnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = none), mode 0 idle / 1 drive / 2 turn, cycles held so far.
    int m_mode = 0;
    int m_owner = -1;
    int m_ptr = 0;
    int m_held = 0;
    initial forever begin
        exp_t e;
        @(posedge CLK);
        if (R) begin
            m_mode = 0; m_owner = -1; m_ptr = 0; m_held = 0;
        end else if (m_mode == 1) begin
            if (!REQ[m_owner] ||
                (LIMIT && m_held >= MAXHOLD && (REQ & ~(4'b0001 << m_owner)) != 4'd0)) begin
                m_mode = 2; m_owner = -1;
            end else begin
                m_held++;
            end
        end else begin
            if (REQ != 4'd0) begin
                for (int k = 0; k < 4; k++)
                    if (m_owner < 0 && REQ[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
                m_ptr  = (m_owner + 1) % 4;
                m_mode = 1;
                m_held = 1;
            end else begin
                m_mode = 0;
            end
        end
        e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        e.busy  = (m_mode != 0);
        e.drive = (m_mode == 1);
        e.hcnt  = 8'((m_held - 1 < MAXHOLD) ? m_held - 1 : MAXHOLD);
        sb.push_back(e);
    end

    // Monitor: compare outputs against the scoreboard and check OE break-before-make every cycle.
    logic [3:0] prev_oe = 4'd0;
    initial forever begin
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("gnt", {28'd0, GNT}, {28'd0, e.gnt});
            check("oe", {28'd0, OE}, {28'd0, e.gnt});
            check("busy", {31'd0, BUSY}, {31'd0, e.busy});
`ifdef TBUF_ARB_HOLD_LIMIT_EN
            if (e.drive) check("hcnt", {24'd0, dut.hcnt_r}, {24'd0, e.hcnt});
`endif
        end
        check("oe_onehot0", {31'd0, $onehot0(OE)}, 32'd1);
        check("oe_bbm", {31'd0, (prev_oe != 4'd0 && OE != 4'd0 && OE != prev_oe)}, 32'd0);
        prev_oe = OE;
    end

    task automatic apply(input logic [3:0] r, input int n);
        @(negedge CLK);
        REQ = r;
        repeat (n - 1) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        R = 1'b1;
        REQ = 4'd0;
        @(negedge CLK);
        R = 1'b0;
    endtask

    initial begin
        logic [3:0] order[$];
        logic [3:0] r;
        logic [3:0] last;
        logic [3:0] exp_order [5];
        int         cnt [4];

        // Reset, single requester grant and release.
        repeat (2) @(negedge CLK);
        check("rst_gnt", {28'd0, GNT}, 32'd0);
        check("rst_oe", {28'd0, OE}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        R = 1'b0;
        apply(4'b0001, 3);
        check("single_gnt", {28'd0, GNT}, 32'h1);
        apply(4'b0000, 4);

        // Everyone requesting, each drops after two granted cycles.
        do_reset();
        r = 4'b1111;
        last = 4'd0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (GNT != 4'd0 && last == 4'd0) order.push_back(GNT);
            last = GNT;
            for (int i = 0; i < 4; i++) begin
                if (GNT[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 2) begin r[i] = 1'b0; cnt[i] = 0; end
                end else begin
                    r[i] = 1'b1;
                end
            end
            REQ = r;
        end
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("rr_count", {31'd0, order.size() >= 5}, 32'd1);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check("rr_order", {28'd0, order[i]}, {28'd0, exp_order[i]});

        // Two contenders held (forced alternation when the limit is built in).
        do_reset();
        apply(4'b0011, 24);

        // Lone requester held well past the limit.
        do_reset();
        apply(4'b0100, 20);
        check("lone_gnt", {28'd0, GNT}, 32'h4);
`ifdef TBUF_ARB_HOLD_LIMIT_EN
        check("lone_hcnt", {24'd0, dut.hcnt_r}, 32'd4);
`endif

        // Asynchronous reset in the middle of a grant to requester 1.
        do_reset();
        apply(4'b0010, 3);
        @(posedge CLK);
        #3;
        R = 1'b1;
        #1;
        check("async_oe", {28'd0, OE}, 32'd0);
        check("async_gnt", {28'd0, GNT}, 32'd0);
        check("async_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        R = 1'b0;
        REQ = 4'b1010;
        @(negedge CLK);
        check("post_rst_gnt", {28'd0, GNT}, 32'h2);

        // Randomised traffic with occasional reset pulses.
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            R = 1'b0;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(5, 0) == 0) REQ[i] = ~REQ[i];
            if ($urandom_range(60, 0) == 0) R = 1'b1;
        end
        @(negedge CLK);
        R = 1'b0;
        REQ = 4'd0;
        repeat (4) @(negedge CLK);
        check("sb_drain", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
